// File: rtl/perm_rho_inv_seq.sv
// rtl/perm_rho_inv_seq.sv - lane-serial inverse Keccak rho (rotate each lane right by its rho offset)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a_rho_in carries a state to de-rotate
//   in_ready   block can accept a state (IDLE only)
//   a_rho_in   rho-domain 5x5x64 state, lane [x][y]
//   out_valid  a_rho_out holds a completed result
//   out_ready  consumer accepts the result
//   a_rho_out  de-rotated state, driven straight from the working register
//   busy       rotation in progress or result waiting
module perm_rho_inv_seq #(
    parameter int X_AXIS = 5,
    parameter int Y_AXIS = 5,
    parameter int Z_AXIS = 64
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  a_rho_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  a_rho_out,
    output logic                                        busy
);

    localparam int LANES = X_AXIS * Y_AXIS;
    localparam int LCW   = $clog2(LANES);
    localparam int XW    = $clog2(X_AXIS);
    localparam int YW    = $clog2(Y_AXIS);
    localparam int SHW   = $clog2(Z_AXIS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                                     state_q;
    logic [LCW-1:0]                             lane_cnt_q;
    // x/y follow lane_cnt (L = 5x + y) so the working lane is addressed without a divider
    logic [XW-1:0]                              x_q;
    logic [YW-1:0]                              y_q;
    logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  work_q;
    logic                                       in_ready_q;
    logic                                       out_valid_q;
    logic                                       busy_q;

    logic [SHW-1:0]                             rot_amt;
    logic [Z_AXIS-1:0]                          lane_rot;

    // Rho offsets in lane order L = 5x + y
    function automatic logic [SHW-1:0] rho_off(input logic [LCW-1:0] l);
        int o;
        case (l)
            5'd0:  o = 0;   5'd1:  o = 36;  5'd2:  o = 3;   5'd3:  o = 41;  5'd4:  o = 18;
            5'd5:  o = 1;   5'd6:  o = 44;  5'd7:  o = 10;  5'd8:  o = 45;  5'd9:  o = 2;
            5'd10: o = 62;  5'd11: o = 6;   5'd12: o = 43;  5'd13: o = 15;  5'd14: o = 61;
            5'd15: o = 28;  5'd16: o = 55;  5'd17: o = 25;  5'd18: o = 21;  5'd19: o = 56;
            5'd20: o = 27;  5'd21: o = 20;  5'd22: o = 39;  5'd23: o = 8;   5'd24: o = 14;
            default: o = 0;
        endcase
        return SHW'(o % Z_AXIS);
    endfunction

    assign rot_amt = rho_off(lane_cnt_q);

    // Shared log-depth right rotator: stage s rotates by 2^s when offset bit s is set
    always_comb begin
        lane_rot = work_q[x_q][y_q];
        for (int s = 0; s < SHW; s++) begin
            if (rot_amt[s]) begin
                lane_rot = (lane_rot >> (1 << s)) | (lane_rot << (Z_AXIS - (1 << s)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_cnt_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= a_rho_in;
                        lane_cnt_q <= '0;
                        x_q        <= '0;
                        y_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ROT;
                    end
                end
                ROT: begin
                    work_q[x_q][y_q] <= lane_rot;
                    if (lane_cnt_q == LCW'(LANES - 1)) begin
                        lane_cnt_q  <= '0;
                        x_q         <= '0;
                        y_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        lane_cnt_q <= lane_cnt_q + 1'b1;
                        if (y_q == YW'(Y_AXIS - 1)) begin
                            y_q <= '0;
                            x_q <= x_q + 1'b1;
                        end else begin
                            y_q <= y_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Working register is left intact so IDLE keeps showing the last result
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign a_rho_out = work_q;

    lane_cnt_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        lane_cnt_q <= LCW'(LANES - 1));

endmodule
